// File: rtl/ex_mem_stage.sv
// EX->MEM pipeline stage register with one-entry skid buffer and synchronous flush.
// Latency: one cycle from an accepted EX instruction to mem_valid with its payload.
// Backpressure: ex_ready comes from registered state only; a MEM stall is absorbed by the skid entry.
//
// Ports:
//   clk, rst            rising-edge clock, synchronous active-low reset
//   flush               kills both held entries and any same-cycle input
//   ex_valid/ex_ready   upstream handshake; ex_* carry the instruction payload
//   mem_valid/mem_ready downstream handshake; mem_* are the registered payload
//                       (all zero whenever mem_valid is low)
// Optional feature macro: EX_MEM_HILO_EN adds the ex_whilo/ex_hi/ex_lo inputs and
// the mem_whilo/mem_hi/mem_lo outputs, carried alongside the rest of the payload.
module ex_mem_stage #(
    parameter int DATA_W  = 32,
    parameter int RADDR_W = 5,
    parameter int MEMOP_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               ex_valid,
    output logic               ex_ready,
    input  logic [RADDR_W-1:0] ex_waddr,
    input  logic [DATA_W-1:0]  ex_wdata,
    input  logic               ex_reg_w,
    input  logic [MEMOP_W-1:0] ex_mem_op,
    input  logic [DATA_W-1:0]  ex_mem_addr,
    input  logic [DATA_W-1:0]  ex_mem_sdata,
`ifdef EX_MEM_HILO_EN
    input  logic               ex_whilo,
    input  logic [DATA_W-1:0]  ex_hi,
    input  logic [DATA_W-1:0]  ex_lo,
    output logic               mem_whilo,
    output logic [DATA_W-1:0]  mem_hi,
    output logic [DATA_W-1:0]  mem_lo,
`endif
    output logic               mem_valid,
    input  logic               mem_ready,
    output logic [RADDR_W-1:0] mem_waddr,
    output logic [DATA_W-1:0]  mem_wdata,
    output logic               mem_write,
    output logic [MEMOP_W-1:0] mem_op,
    output logic [DATA_W-1:0]  mem_addr,
    output logic [DATA_W-1:0]  mem_sdata
);

    typedef struct packed {
        logic [RADDR_W-1:0] waddr;
        logic [DATA_W-1:0]  wdata;
        logic               reg_w;
        logic [MEMOP_W-1:0] op;
        logic [DATA_W-1:0]  addr;
        logic [DATA_W-1:0]  sdata;
`ifdef EX_MEM_HILO_EN
        logic               whilo;
        logic [DATA_W-1:0]  hi;
        logic [DATA_W-1:0]  lo;
`endif
    } ent_t;

    // EMPTY: nothing held. BUSY: output entry only. FULL: output + skid entry.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_BUSY  = 2'd1,
        ST_FULL  = 2'd2
    } state_e;

    state_e state_q;
    ent_t   out_q;
    ent_t   skd_q;
    ent_t   in_ent;
    logic   accept;
    logic   drain;

    assign in_ent.waddr = ex_waddr;
    assign in_ent.wdata = ex_wdata;
    assign in_ent.reg_w = ex_reg_w;
    assign in_ent.op    = ex_mem_op;
    assign in_ent.addr  = ex_mem_addr;
    assign in_ent.sdata = ex_mem_sdata;
`ifdef EX_MEM_HILO_EN
    assign in_ent.whilo = ex_whilo;
    assign in_ent.hi    = ex_hi;
    assign in_ent.lo    = ex_lo;
`endif

    // Ready depends only on the skid occupancy (and reset), never on mem_ready,
    // so EX sees no combinational path through this stage.
    assign ex_ready  = rst & (state_q != ST_FULL);
    assign mem_valid = (state_q != ST_EMPTY);
    assign accept    = ex_valid & ex_ready;
    assign drain     = mem_valid & mem_ready;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_EMPTY;
            out_q   <= '0;
            skd_q   <= '0;
        end else if (flush) begin
            // Same-cycle accept and drain are both discarded.
            state_q <= ST_EMPTY;
            out_q   <= '0;
            skd_q   <= '0;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        out_q   <= in_ent;
                        state_q <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (drain && accept) begin
                        out_q <= in_ent;
                    end else if (drain) begin
                        // Zero the payload so invalid outputs read as 0.
                        out_q   <= '0;
                        state_q <= ST_EMPTY;
                    end else if (accept) begin
                        skd_q   <= in_ent;
                        state_q <= ST_FULL;
                    end
                end
                ST_FULL: begin
                    // ex_ready is low here, so only the skid shift can happen.
                    if (drain) begin
                        out_q   <= skd_q;
                        skd_q   <= '0;
                        state_q <= ST_BUSY;
                    end
                end
                default: begin
                    state_q <= ST_EMPTY;
                    out_q   <= '0;
                    skd_q   <= '0;
                end
            endcase
        end
    end

    assign mem_waddr = out_q.waddr;
    assign mem_wdata = out_q.wdata;
    assign mem_write = out_q.reg_w;
    assign mem_op    = out_q.op;
    assign mem_addr  = out_q.addr;
    assign mem_sdata = out_q.sdata;
`ifdef EX_MEM_HILO_EN
    assign mem_whilo = out_q.whilo;
    assign mem_hi    = out_q.hi;
    assign mem_lo    = out_q.lo;
`endif

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed bench for ex_mem_stage: table of per-cycle vectors plus a
// stall/gap sequence that checks FIFO ordering through the skid entry.
// Side payload fields are derived from wdata so one table column drives them all.
`timescale 1ns/1ps
module tb_ex_mem_stage;
    localparam int DW = 32;
    localparam int RW = 5;
    localparam int MW = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, flush, ex_valid, ex_ready, ex_reg_w;
    logic          mem_valid, mem_ready, mem_write;
    logic [RW-1:0] ex_waddr, mem_waddr;
    logic [DW-1:0] ex_wdata, ex_mem_addr, ex_mem_sdata;
    logic [DW-1:0] mem_wdata, mem_addr, mem_sdata;
    logic [MW-1:0] ex_mem_op, mem_op;
`ifdef EX_MEM_HILO_EN
    logic          ex_whilo, mem_whilo;
    logic [DW-1:0] ex_hi, ex_lo, mem_hi, mem_lo;
`endif

    int checks = 0;
    int errors = 0;

    ex_mem_stage #(.DATA_W(DW), .RADDR_W(RW), .MEMOP_W(MW)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .ex_valid(ex_valid), .ex_ready(ex_ready),
        .ex_waddr(ex_waddr), .ex_wdata(ex_wdata), .ex_reg_w(ex_reg_w),
        .ex_mem_op(ex_mem_op), .ex_mem_addr(ex_mem_addr), .ex_mem_sdata(ex_mem_sdata),
`ifdef EX_MEM_HILO_EN
        .ex_whilo(ex_whilo), .ex_hi(ex_hi), .ex_lo(ex_lo),
        .mem_whilo(mem_whilo), .mem_hi(mem_hi), .mem_lo(mem_lo),
`endif
        .mem_valid(mem_valid), .mem_ready(mem_ready),
        .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .mem_write(mem_write),
        .mem_op(mem_op), .mem_addr(mem_addr), .mem_sdata(mem_sdata)
    );

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic f, input logic v,
                         input logic [RW-1:0] wa, input logic [DW-1:0] wd,
                         input logic rw, input logic mr);
        rst          = r;
        flush        = f;
        ex_valid     = v;
        ex_waddr     = wa;
        ex_wdata     = wd;
        ex_reg_w     = rw;
        ex_mem_op    = wd[MW-1:0];
        ex_mem_addr  = wd + 32'h100;
        ex_mem_sdata = ~wd;
`ifdef EX_MEM_HILO_EN
        ex_whilo     = ~wd[4];
        ex_hi        = wd ^ 32'h1;
        ex_lo        = wd ^ 32'h2;
`endif
        mem_ready    = mr;
    endtask

    // Expected derived fields are zero whenever the entry is invalid.
    task automatic check_payload(input string tag, input logic mv,
                                 input logic [RW-1:0] wa, input logic [DW-1:0] wd, input logic rw);
        logic [DW-1:0] exp_op;
        exp_op = 32'(wd[MW-1:0]);
        chk({tag, ".mem_valid"}, 32'(mem_valid), 32'(mv));
        chk({tag, ".mem_waddr"}, 32'(mem_waddr), 32'(wa));
        chk({tag, ".mem_wdata"}, mem_wdata, wd);
        chk({tag, ".mem_write"}, 32'(mem_write), 32'(rw));
        chk({tag, ".mem_op"},    32'(mem_op),    mv ? exp_op : 32'h0);
        chk({tag, ".mem_addr"},  mem_addr,       mv ? wd + 32'h100 : 32'h0);
        chk({tag, ".mem_sdata"}, mem_sdata,      mv ? ~wd : 32'h0);
`ifdef EX_MEM_HILO_EN
        chk({tag, ".mem_whilo"}, 32'(mem_whilo), mv ? 32'(~wd[4]) : 32'h0);
        chk({tag, ".mem_hi"},    mem_hi,         mv ? wd ^ 32'h1 : 32'h0);
        chk({tag, ".mem_lo"},    mem_lo,         mv ? wd ^ 32'h2 : 32'h0);
`endif
    endtask

    typedef struct {
        logic          r, f, v;
        logic [RW-1:0] wa;
        logic [DW-1:0] wd;
        logic          rw, mr;
        logic          er, mv;   // expected after the edge
        logic [RW-1:0] ewa;
        logic [DW-1:0] ewd;
        logic          ew;
    } vec_t;

    function automatic vec_t mk(input logic r, input logic f, input logic v,
                                input logic [RW-1:0] wa, input logic [DW-1:0] wd,
                                input logic rw, input logic mr,
                                input logic er, input logic mv,
                                input logic [RW-1:0] ewa, input logic [DW-1:0] ewd, input logic ew);
        vec_t t;
        t.r = r; t.f = f; t.v = v; t.wa = wa; t.wd = wd; t.rw = rw; t.mr = mr;
        t.er = er; t.mv = mv; t.ewa = ewa; t.ewd = ewd; t.ew = ew;
        return t;
    endfunction

    localparam int NV = 25;
    vec_t tv[NV];

    initial begin
        //            r  f  v  wa     wd          rw mr   er mv ewa    ewd        ew
        // reset
        tv[0]  = mk(0, 0, 0, 5'd0,  32'h0,      0, 0,   0, 0, 5'd0,  32'h0,     0);
        tv[1]  = mk(0, 1, 1, 5'd3,  32'h77,     1, 1,   0, 0, 5'd0,  32'h0,     0);
        // stream 1..4 at full rate
        tv[2]  = mk(1, 0, 1, 5'd1,  32'h11,     1, 1,   1, 1, 5'd1,  32'h11,    1);
        tv[3]  = mk(1, 0, 1, 5'd2,  32'h22,     1, 1,   1, 1, 5'd2,  32'h22,    1);
        tv[4]  = mk(1, 0, 1, 5'd3,  32'h33,     1, 1,   1, 1, 5'd3,  32'h33,    1);
        tv[5]  = mk(1, 0, 1, 5'd4,  32'h44,     1, 1,   1, 1, 5'd4,  32'h44,    1);
        tv[6]  = mk(1, 0, 0, 5'd31, 32'hBAD,    1, 1,   1, 0, 5'd0,  32'h0,     0);
        // backpressure: A, B fill OUT/SKD, C held until space
        tv[7]  = mk(1, 0, 1, 5'd5,  32'h10,     1, 0,   1, 1, 5'd5,  32'h10,    1);
        tv[8]  = mk(1, 0, 1, 5'd6,  32'h20,     1, 0,   0, 1, 5'd5,  32'h10,    1);
        tv[9]  = mk(1, 0, 1, 5'd7,  32'h30,     1, 0,   0, 1, 5'd5,  32'h10,    1);
        tv[10] = mk(1, 0, 1, 5'd7,  32'h30,     1, 1,   1, 1, 5'd6,  32'h20,    1);
        tv[11] = mk(1, 0, 1, 5'd7,  32'h30,     1, 1,   1, 1, 5'd7,  32'h30,    1);
        tv[12] = mk(1, 0, 0, 5'd9,  32'h5A5A,   1, 1,   1, 0, 5'd0,  32'h0,     0);
        // single entry drains to empty
        tv[13] = mk(1, 0, 1, 5'd8,  32'hDEAD,   1, 1,   1, 1, 5'd8,  32'hDEAD,  1);
        tv[14] = mk(1, 0, 0, 5'd8,  32'hDEAD,   1, 1,   1, 0, 5'd0,  32'h0,     0);
        // flush while FULL with accept and drain requested
        tv[15] = mk(1, 0, 1, 5'd9,  32'h90,     0, 0,   1, 1, 5'd9,  32'h90,    0);
        tv[16] = mk(1, 0, 1, 5'd10, 32'hA0,     1, 0,   0, 1, 5'd9,  32'h90,    0);
        tv[17] = mk(1, 1, 1, 5'd11, 32'hB0,     1, 1,   1, 0, 5'd0,  32'h0,     0);
        tv[18] = mk(1, 0, 0, 5'd11, 32'hB0,     1, 1,   1, 0, 5'd0,  32'h0,     0);
        // reset while FULL
        tv[19] = mk(1, 0, 1, 5'd12, 32'hC0,     1, 0,   1, 1, 5'd12, 32'hC0,    1);
        tv[20] = mk(1, 0, 1, 5'd13, 32'hD0,     1, 0,   0, 1, 5'd12, 32'hC0,    1);
        tv[21] = mk(0, 0, 1, 5'd14, 32'hE0,     1, 1,   0, 0, 5'd0,  32'h0,     0);
        tv[22] = mk(1, 0, 0, 5'd14, 32'hE0,     1, 1,   1, 0, 5'd0,  32'h0,     0);
        tv[23] = mk(1, 0, 1, 5'd15, 32'hF0,     1, 1,   1, 1, 5'd15, 32'hF0,    1);
        tv[24] = mk(1, 0, 0, 5'd15, 32'hF0,     1, 1,   1, 0, 5'd0,  32'h0,     0);

        drive(0, 0, 0, '0, '0, 0, 0);

        // Inputs change mid-low phase; outputs are checked 1ns after the rising edge
        // while that vector's inputs are still applied.
        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            drive(tv[i].r, tv[i].f, tv[i].v, tv[i].wa, tv[i].wd, tv[i].rw, tv[i].mr);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d.ex_ready", i), 32'(ex_ready), 32'(tv[i].er));
            check_payload($sformatf("v%0d", i), tv[i].mv, tv[i].ewa, tv[i].ewd, tv[i].ew);
        end

        // Ordering under irregular producer gaps and consumer stalls.
        begin
            int sent = 0;
            int rcvd = 0;
            int cyc  = 0;
            while (rcvd < 8 && cyc < 200) begin
                @(negedge clk);
                drive(1, 0, (sent < 8) && ((cyc % 5) != 4), RW'(sent + 16),
                      32'(32'h1000 * (sent + 1) + sent), sent[0], (cyc % 3) != 0);
                #1;
                if (mem_valid && mem_ready) begin
                    check_payload($sformatf("seq%0d", rcvd), 1'b1, RW'(rcvd + 16),
                                  32'(32'h1000 * (rcvd + 1) + rcvd), rcvd[0]);
                    rcvd++;
                end
                if (ex_valid && ex_ready) sent++;
                cyc++;
            end
            checks++;
            if (rcvd != 8) begin
                errors++;
                $display("FAIL seq.count: received %0d entries, expected 8 within 200 cycles", rcvd);
            end
        end

        // After the stream, the stage must empty out with zeroed payload.
        @(negedge clk);
        drive(1, 0, 0, 5'd1, 32'h1234, 1, 1);
        @(posedge clk);
        #1;
        @(negedge clk);
        @(posedge clk);
        #1;
        chk("tail.ex_ready", 32'(ex_ready), 32'h1);
        check_payload("tail", 1'b0, '0, '0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
